// File: rtl/soc_periph_pkg.sv
// Shared definitions for SoC peripheral-bus blocks: register offsets, CTRL fields, reset defaults.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package soc_periph_pkg;

    // Word offsets within the machine-timer block
    localparam logic [2:0] MTIME_LO    = 3'd0;
    localparam logic [2:0] MTIME_HI    = 3'd1;
    localparam logic [2:0] MTIMECMP_LO = 3'd2;
    localparam logic [2:0] MTIMECMP_HI = 3'd3;
    localparam logic [2:0] CTRL        = 3'd4;

    // CTRL register field positions
    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_PRESC_LSB = 16;

    // Compare register resets to all-ones so no interrupt fires before software programs it
    localparam logic [63:0] MTIMER_RST_CMP = 64'hFFFF_FFFF_FFFF_FFFF;

    // Bus handshake states
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } bus_state_t;

endpackage

// File: rtl/rv_mtimer_if.sv
// Peripheral bus bundle between the SoC bus master and the machine timer.
// Latency: n/a (wires only).
// Backpressure: none on the bus; the slave completes every request with a one-cycle ack.
interface rv_mtimer_if;
    logic        sel;
    logic        we;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;

    modport master (output sel, we, addr, wdata, input rdata, ack);
    modport slave  (input sel, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/mtimer_prescaler.sv
// Prescaler for mtime: issues one tick every PRESC+1 enabled cycles.
// Latency: tick is combinational from the current count; count updates each clock.
// Backpressure: none; EN=0 freezes the count, clear restarts it from 0.
module mtimer_prescaler #(
    parameter int PRESC_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_en,
    input  logic [PRESC_W-1:0] i_presc,
    input  logic               i_clr,
    output logic               o_tick
);

    logic [PRESC_W-1:0] r_cnt;

    assign o_tick = i_en && (r_cnt == i_presc);

    // Count enabled cycles, wrapping to 0 on each tick; a CTRL write restarts the period
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (o_tick) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/rv_mtimer.sv
// RISC-V machine timer: 64-bit mtime with prescaler, mtimecmp, level timer interrupt.
// Latency: bus access acks one cycle after acceptance; timer_int is registered (1 cycle).
// Backpressure: one access per 2 cycles; sel held through ack starts the next access after ack.
module rv_mtimer
    import soc_periph_pkg::*;
#(
    parameter int          PRESC_W = 16,
    parameter logic [63:0] RST_CMP = MTIMER_RST_CMP
) (
    input  logic        clk,
    input  logic        reset_n,
    rv_mtimer_if.slave  bus,
    output logic        timer_int
);

    bus_state_t         r_state;
    bus_state_t         w_state_nxt;
    logic               w_accept;

    logic [63:0]        r_mtime;
    logic [63:0]        r_mtimecmp;
    logic               r_en;
    logic [PRESC_W-1:0] r_presc;
    logic [31:0]        r_rdata;
    logic               r_timer_int;

    logic               w_tick;
    logic               w_wr;
    logic               w_wr_mtime_lo;
    logic               w_wr_mtime_hi;
    logic               w_wr_cmp_lo;
    logic               w_wr_cmp_hi;
    logic               w_wr_ctrl;
    logic [31:0]        w_ctrl_val;
    logic [31:0]        w_rd_val;

    // Bus FSM next state: accept only from IDLE, so ack is never back-to-back
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.sel) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_ACK;
                end
            end
            ST_ACK:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Bus FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign w_wr          = w_accept && bus.we;
    assign w_wr_mtime_lo = w_wr && (bus.addr == MTIME_LO);
    assign w_wr_mtime_hi = w_wr && (bus.addr == MTIME_HI);
    assign w_wr_cmp_lo   = w_wr && (bus.addr == MTIMECMP_LO);
    assign w_wr_cmp_hi   = w_wr && (bus.addr == MTIMECMP_HI);
    assign w_wr_ctrl     = w_wr && (bus.addr == CTRL);

    mtimer_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_presc (
        .clk     (clk),
        .reset_n (reset_n),
        .i_en    (r_en),
        .i_presc (r_presc),
        .i_clr   (w_wr_ctrl),
        .o_tick  (w_tick)
    );

    // Assemble CTRL readback; unimplemented bits read as zero
    always_comb begin
        w_ctrl_val                              = '0;
        w_ctrl_val[CTRL_EN_BIT]                 = r_en;
        w_ctrl_val[CTRL_PRESC_LSB +: PRESC_W]   = r_presc;
    end

    // Read mux over current register values; holes at offsets 5-7 read zero
    always_comb begin
        w_rd_val = '0;
        case (bus.addr)
            MTIME_LO:    w_rd_val = r_mtime[31:0];
            MTIME_HI:    w_rd_val = r_mtime[63:32];
            MTIMECMP_LO: w_rd_val = r_mtimecmp[31:0];
            MTIMECMP_HI: w_rd_val = r_mtimecmp[63:32];
            CTRL:        w_rd_val = w_ctrl_val;
            default:     w_rd_val = '0;
        endcase
    end

    // Capture read data at the accepting edge; rdata is zero whenever ack is low
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rdata <= '0;
        end else if (w_accept && !bus.we) begin
            r_rdata <= w_rd_val;
        end else begin
            r_rdata <= '0;
        end
    end

    assign bus.rdata = r_rdata;
    assign bus.ack   = (r_state == ST_ACK);

    // mtime: a software write to either half wins and drops a coincident tick entirely
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mtime <= '0;
        end else if (w_wr_mtime_lo) begin
            r_mtime[31:0] <= bus.wdata;
        end else if (w_wr_mtime_hi) begin
            r_mtime[63:32] <= bus.wdata;
        end else if (w_tick) begin
            r_mtime <= r_mtime + 64'd1;
        end
    end

    // mtimecmp halves are written independently; software sequences HI/LO/HI
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mtimecmp <= RST_CMP;
        end else if (w_wr_cmp_lo) begin
            r_mtimecmp[31:0] <= bus.wdata;
        end else if (w_wr_cmp_hi) begin
            r_mtimecmp[63:32] <= bus.wdata;
        end
    end

    // CTRL: enable and prescaler divisor
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_en    <= 1'b1;
            r_presc <= '0;
        end else if (w_wr_ctrl) begin
            r_en    <= bus.wdata[CTRL_EN_BIT];
            r_presc <= bus.wdata[CTRL_PRESC_LSB +: PRESC_W];
        end
    end

    // Interrupt level follows the unsigned compare one cycle later; never self-clears
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_timer_int <= 1'b0;
        end else begin
            r_timer_int <= (r_mtime >= r_mtimecmp);
        end
    end

    assign timer_int = r_timer_int;

endmodule

// File: tb/tb_rv_mtimer.sv
// Directed bench for rv_mtimer: bus accesses, prescaler, carry/wrap, compare and reset behaviour.
// Latency: each bus access occupies two cycles (accept, ack) and returns on a falling edge.
// Backpressure: the bench never overlaps accesses; sel drops in the ack cycle.
module tb_rv_mtimer;
    import soc_periph_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        timer_int;
    logic        ti_at_ack;
    logic [31:0] rd;
    int          total = 0;
    int          bad   = 0;

    rv_mtimer_if bif ();

    rv_mtimer #(
        .PRESC_W (16),
        .RST_CMP (64'hFFFF_FFFF_FFFF_FFFF)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bif),
        .timer_int (timer_int)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge with the FSM idle; returns on a falling edge with the FSM idle
    task automatic bus_xfer(input logic w, input logic [2:0] a, input logic [31:0] d,
                            output logic [31:0] rdat);
        bif.sel   = 1'b1;
        bif.we    = w;
        bif.addr  = a;
        bif.wdata = d;
        @(negedge clk);
        check("ack_hi", bif.ack, 1'b1);
        rdat      = bif.rdata;
        ti_at_ack = timer_int;
        bif.sel   = 1'b0;
        bif.we    = 1'b0;
        @(negedge clk);
        check("ack_lo", bif.ack, 1'b0);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        bus_xfer(1'b1, a, d, dummy);
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] v;
        bus_xfer(1'b0, a, 32'h0, v);
        check(tag, v, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        bif.sel   = 1'b0;
        bif.we    = 1'b0;
        bif.addr  = 3'd0;
        bif.wdata = 32'h0;
        reset_n   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ack",   bif.ack,   1'b0);
        check("rst_rdata", bif.rdata, 32'h0);
        check("rst_int",   timer_int, 1'b0);
        reset_n = 1'b1;

        // Free-running after reset with default CTRL
        repeat (10) @(negedge clk);
        rd_chk("idle_mtime_lo", MTIME_LO, 32'd10);
        check("idle_int", timer_int, 1'b0);
        rd_chk("ctrl_reset", CTRL, 32'h0000_0001);

        // Compare: interrupt rises one cycle after mtime reaches 20
        wr(CTRL, 32'h0);
        wr(MTIME_LO, 32'h0);
        wr(MTIME_HI, 32'h0);
        wr(MTIMECMP_HI, 32'h0);
        wr(MTIMECMP_LO, 32'd20);
        check("int_frozen", timer_int, 1'b0);
        wr(CTRL, 32'h0000_0001);
        repeat (19) @(negedge clk);
        check("int_at_20", timer_int, 1'b0);
        @(negedge clk);
        check("int_rise", timer_int, 1'b1);
        wr(MTIMECMP_LO, 32'd1000);
        check("int_at_cmp_ack", ti_at_ack, 1'b1);
        check("int_fall", timer_int, 1'b0);

        // Prescaler = 3: one increment every 4 cycles, then freeze
        wr(CTRL, 32'h0);
        wr(MTIME_LO, 32'h0);
        wr(MTIME_HI, 32'h0);
        wr(CTRL, 32'h0003_0001);
        repeat (3) @(negedge clk);
        rd_chk("presc_a", MTIME_LO, 32'd1);
        repeat (2) @(negedge clk);
        rd_chk("presc_b", MTIME_LO, 32'd2);
        repeat (10) @(negedge clk);
        rd_chk("presc_c", MTIME_LO, 32'd5);
        wr(CTRL, 32'h0);
        rd_chk("frozen_a", MTIME_LO, 32'd5);
        repeat (50) @(negedge clk);
        rd_chk("frozen_b", MTIME_LO, 32'd5);

        // Carry from LO into HI after two ticks
        wr(MTIME_HI, 32'h0);
        wr(MTIME_LO, 32'hFFFF_FFFE);
        wr(CTRL, 32'h0000_0001);
        wr(CTRL, 32'h0);
        rd_chk("carry_hi", MTIME_HI, 32'd1);
        rd_chk("carry_lo", MTIME_LO, 32'd0);

        // 64-bit wrap to zero on a single tick; interrupt clears as mtime drops
        wr(MTIME_HI, 32'hFFFF_FFFF);
        wr(MTIME_LO, 32'hFFFF_FFFF);
        check("int_max_mtime", timer_int, 1'b1);
        wr(CTRL, 32'h0001_0001);
        wr(CTRL, 32'h0);
        check("int_after_wrap", timer_int, 1'b0);
        rd_chk("wrap_lo", MTIME_LO, 32'd0);
        rd_chk("wrap_hi", MTIME_HI, 32'd0);

        // Write to MTIME_LO lands on the same edge as a tick (PRESC=15)
        wr(MTIME_HI, 32'd7);
        wr(MTIME_LO, 32'hFFFF_FFFF);
        wr(CTRL, 32'h000F_0001);
        repeat (14) @(negedge clk);
        wr(MTIME_LO, 32'd5);
        rd_chk("coinc_lo", MTIME_LO, 32'd5);
        rd_chk("coinc_hi", MTIME_HI, 32'd7);

        // Unmapped offset: acked, reads zero, no side effects
        wr(3'd6, 32'hDEAD_BEEF);
        rd_chk("hole_rd", 3'd6, 32'h0);
        rd_chk("hole_ctrl", CTRL, 32'h000F_0001);
        rd_chk("hole_cmp_lo", MTIMECMP_LO, 32'd1000);
        rd_chk("hole_mtime_hi", MTIME_HI, 32'd7);

        // Reset asserted while interrupt is high and an ack is pending
        wr(MTIMECMP_LO, 32'h0);
        check("int_pre_reset", timer_int, 1'b1);
        bif.sel  = 1'b1;
        bif.we   = 1'b0;
        bif.addr = MTIME_LO;
        @(posedge clk);
        #1;
        check("ack_pending", bif.ack, 1'b1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_int",   timer_int, 1'b0);
        check("mid_rst_ack",   bif.ack,   1'b0);
        check("mid_rst_rdata", bif.rdata, 32'h0);
        bif.sel = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        rd_chk("post_rst_mtime_lo", MTIME_LO, 32'd0);
        rd_chk("post_rst_mtime_hi", MTIME_HI, 32'd0);
        rd_chk("post_rst_cmp_lo", MTIMECMP_LO, 32'hFFFF_FFFF);
        rd_chk("post_rst_cmp_hi", MTIMECMP_HI, 32'hFFFF_FFFF);
        rd_chk("post_rst_ctrl", CTRL, 32'h0000_0001);
        check("post_rst_int", timer_int, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
